// File: rtl/c_demux2_2b_cache.sv
`default_nettype none
// ============================================================================
//  Module      : c_demux2_2b_cache
//  Description : Two-way drive/free token demultiplexer for the cache control
//                handshake network. Each incoming token is steered by i_sel
//                into one of two one-entry output slots. A single pending
//                register absorbs a token whose target slot is still busy.
//                Upstream receives one o_free pulse per token handed into a
//                slot, plus one initial credit after reset.
//
//  Ports       : clk          - clock, rising edge
//                rst          - synchronous active-high reset
//                i_drive      - upstream token valid pulse
//                i_data       - upstream token payload
//                i_sel        - destination select (0 -> out 0, 1 -> out 1)
//                o_free       - upstream credit pulse
//                o_drive0/1   - token presented on output 0 / 1
//                o_data0/1    - slot payload for output 0 / 1
//                i_free0/1    - downstream 0 / 1 consumed its token
//                o_proto_err  - sticky upstream protocol violation flag
//
//  Revision    : 1.0 - initial release
// ============================================================================
module c_demux2_2b_cache #(
    parameter int DATA_W = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_drive,
    input  logic [DATA_W-1:0] i_data,
    input  logic              i_sel,
    output logic              o_free,
    output logic              o_drive0,
    output logic              o_drive1,
    output logic [DATA_W-1:0] o_data0,
    output logic [DATA_W-1:0] o_data1,
    input  logic              i_free0,
    input  logic              i_free1,
    output logic              o_proto_err
);

    // Per-slot state encoding
    localparam logic [1:0] S_EMPTY = 2'd0;
    localparam logic [1:0] S_SEND  = 2'd1;
    localparam logic [1:0] S_WAIT  = 2'd2;

    // Slot state and payload
    logic [1:0]        r_state     [2];
    logic [1:0]        w_state_nxt [2];
    logic [DATA_W-1:0] r_slot_data [2];
    logic              w_drive     [2];

    // Pending register
    logic              r_pend_valid;
    logic              r_pend_sel;
    logic [DATA_W-1:0] r_pend_data;

    // Credit / error registers
    logic              r_free;
    logic              r_credit_given;
    logic              r_proto_err;

    // Acceptance decisions for the current edge
    logic [1:0]        w_free_in;
    logic [1:0]        w_avail;
    logic [1:0]        w_load;
    logic [DATA_W-1:0] w_load_data;
    logic              w_pend_set;
    logic              w_pend_clr;
    logic              w_accept;
    logic              w_err;

    assign w_free_in = {i_free1, i_free0};

    // A slot can take a token at this edge if it is empty, or if its current
    // token is being consumed at this same edge (free in EMPTY is harmless
    // because EMPTY is already available).
    always_comb begin
        for (int i = 0; i < 2; i++) begin
            w_avail[i] = (r_state[i] == S_EMPTY) || w_free_in[i];
        end
    end

    // Token steering. A compliant upstream never drives while pending is
    // valid, so pending and i_drive never compete for a load; if they do,
    // the new token is the one discarded.
    always_comb begin
        w_load      = 2'b00;
        w_load_data = r_pend_data;
        w_pend_set  = 1'b0;
        w_pend_clr  = 1'b0;
        w_accept    = 1'b0;
        w_err       = 1'b0;
        if (r_pend_valid) begin
            if (w_avail[r_pend_sel]) begin
                w_load[r_pend_sel] = 1'b1;
                w_pend_clr         = 1'b1;
                w_accept           = 1'b1;
            end
            if (i_drive) begin
                w_err = 1'b1;
            end
        end else if (i_drive) begin
            w_load_data = i_data;
            if (w_avail[i_sel]) begin
                w_load[i_sel] = 1'b1;
                w_accept      = 1'b1;
            end else begin
                w_pend_set = 1'b1;
            end
        end
    end

    // ------------------------------------------------------------------
    // Slot FSMs: state register
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        for (int i = 0; i < 2; i++) begin
            if (rst) begin
                r_state[i] <= S_EMPTY;
            end else begin
                r_state[i] <= w_state_nxt[i];
            end
        end
    end

    // ------------------------------------------------------------------
    // Slot FSMs: next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        for (int i = 0; i < 2; i++) begin
            w_state_nxt[i] = r_state[i];
            if (w_load[i]) begin
                // Loads only happen when the slot is empty or being freed,
                // so a load always restarts the SEND cycle.
                w_state_nxt[i] = S_SEND;
            end else begin
                case (r_state[i])
                    S_EMPTY: w_state_nxt[i] = S_EMPTY;
                    S_SEND:  w_state_nxt[i] = w_free_in[i] ? S_EMPTY : S_WAIT;
                    S_WAIT:  w_state_nxt[i] = w_free_in[i] ? S_EMPTY : S_WAIT;
                    default: w_state_nxt[i] = S_EMPTY;
                endcase
            end
        end
    end

    // ------------------------------------------------------------------
    // Slot FSMs: output decode
    // ------------------------------------------------------------------
    always_comb begin
        for (int i = 0; i < 2; i++) begin
            w_drive[i] = (r_state[i] == S_SEND);
        end
    end

    // Slot payload: captured on load, otherwise held (including while EMPTY)
    always_ff @(posedge clk) begin
        for (int i = 0; i < 2; i++) begin
            if (rst) begin
                r_slot_data[i] <= '0;
            end else if (w_load[i]) begin
                r_slot_data[i] <= w_load_data;
            end
        end
    end

    // Pending register
    always_ff @(posedge clk) begin
        if (rst) begin
            r_pend_valid <= 1'b0;
            r_pend_sel   <= 1'b0;
            r_pend_data  <= '0;
        end else if (w_pend_set) begin
            r_pend_valid <= 1'b1;
            r_pend_sel   <= i_sel;
            r_pend_data  <= i_data;
        end else if (w_pend_clr) begin
            r_pend_valid <= 1'b0;
        end
    end

    // Credit pulse and sticky error. r_credit_given makes the first edge
    // out of reset emit the single initial credit.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_free         <= 1'b0;
            r_credit_given <= 1'b0;
            r_proto_err    <= 1'b0;
        end else begin
            r_free         <= w_accept || !r_credit_given;
            r_credit_given <= 1'b1;
            if (w_err) begin
                r_proto_err <= 1'b1;
            end
        end
    end

    assign o_free      = r_free;
    assign o_drive0    = w_drive[0];
    assign o_drive1    = w_drive[1];
    assign o_data0     = r_slot_data[0];
    assign o_data1     = r_slot_data[1];
    assign o_proto_err = r_proto_err;

endmodule
`default_nettype wire

// File: tb/tb_c_demux2_2b_cache.sv
`default_nettype none
// ============================================================================
//  Module      : tb_c_demux2_2b_cache
//  Description : Directed self-checking bench for c_demux2_2b_cache.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_c_demux2_2b_cache;

    logic       clk;
    logic       rst;
    logic       i_drive;
    logic [1:0] i_data;
    logic       i_sel;
    logic       o_free;
    logic       o_drive0;
    logic       o_drive1;
    logic [1:0] o_data0;
    logic [1:0] o_data1;
    logic       i_free0;
    logic       i_free1;
    logic       o_proto_err;

    int n_checks;
    int n_fail;

    c_demux2_2b_cache #(.DATA_W(2)) dut (
        .clk         (clk),
        .rst         (rst),
        .i_drive     (i_drive),
        .i_data      (i_data),
        .i_sel       (i_sel),
        .o_free      (o_free),
        .o_drive0    (o_drive0),
        .o_drive1    (o_drive1),
        .o_data0     (o_data0),
        .o_data1     (o_data1),
        .i_free0     (i_free0),
        .i_free1     (i_free1),
        .o_proto_err (o_proto_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance one edge; outputs are observed 1 time unit after it and
    // inputs changed from there are sampled at the following edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        i_drive = 1'b0;
        i_data  = 2'b00;
        i_sel   = 1'b0;
        i_free0 = 1'b0;
        i_free1 = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        idle_inputs();
        for (int k = 0; k < 3; k++) begin
            step();
            n_checks++; if ({o_free, o_drive0, o_drive1, o_data0, o_data1, o_proto_err} !== 8'h00) begin n_fail++; $display("FAIL reset_outs cycle %0d got=%b want=00000000", k, {o_free, o_drive0, o_drive1, o_data0, o_data1, o_proto_err}); end
        end
        rst = 1'b0;
        step();
        n_checks++; if (o_free !== 1'b1) begin n_fail++; $display("FAIL init_credit got=%b want=1", o_free); end
        step();
        n_checks++; if (o_free !== 1'b0) begin n_fail++; $display("FAIL init_credit_once got=%b want=0", o_free); end
    endtask

    task automatic test_single_route();
        i_drive = 1'b1; i_sel = 1'b1; i_data = 2'b10;
        step();
        idle_inputs();
        n_checks++; if ({o_drive1, o_data1, o_free, o_drive0} !== 5'b1_10_1_0) begin n_fail++; $display("FAIL route1 {drv1,dat1,free,drv0} got=%b want=11010", {o_drive1, o_data1, o_free, o_drive0}); end
        step();
        n_checks++; if ({o_drive1, o_free} !== 2'b00) begin n_fail++; $display("FAIL route1_wait {drv1,free} got=%b want=00", {o_drive1, o_free}); end
        i_free1 = 1'b1;
        step();
        idle_inputs();
        n_checks++; if (o_drive1 !== 1'b0) begin n_fail++; $display("FAIL route1_freed drv1 got=%b want=0", o_drive1); end
        // Slot 1 must be EMPTY: a new token routes with 1-cycle latency
        i_drive = 1'b1; i_sel = 1'b1; i_data = 2'b01;
        step();
        idle_inputs();
        n_checks++; if ({o_drive1, o_data1, o_free} !== 4'b1_01_1) begin n_fail++; $display("FAIL route1_again {drv1,dat1,free} got=%b want=1011", {o_drive1, o_data1, o_free}); end
        i_free1 = 1'b1;
        step();
        idle_inputs();
    endtask

    task automatic test_pending_stall();
        i_drive = 1'b1; i_sel = 1'b0; i_data = 2'b11;
        step();
        n_checks++; if ({o_drive0, o_data0, o_free} !== 4'b1_11_1) begin n_fail++; $display("FAIL stall_first {drv0,dat0,free} got=%b want=1111", {o_drive0, o_data0, o_free}); end
        i_data = 2'b01;
        step();
        idle_inputs();
        n_checks++; if ({o_drive0, o_data0, o_free} !== 4'b0_11_0) begin n_fail++; $display("FAIL stall_pend {drv0,dat0,free} got=%b want=0110", {o_drive0, o_data0, o_free}); end
        step();
        n_checks++; if ({o_drive0, o_free} !== 2'b00) begin n_fail++; $display("FAIL stall_hold {drv0,free} got=%b want=00", {o_drive0, o_free}); end
        i_free0 = 1'b1;
        step();
        idle_inputs();
        n_checks++; if ({o_drive0, o_data0, o_free} !== 4'b1_01_1) begin n_fail++; $display("FAIL stall_drain {drv0,dat0,free} got=%b want=1011", {o_drive0, o_data0, o_free}); end
        step();
        n_checks++; if ({o_drive0, o_free} !== 2'b00) begin n_fail++; $display("FAIL stall_after {drv0,free} got=%b want=00", {o_drive0, o_free}); end
        i_free0 = 1'b1;
        step();
        idle_inputs();
    endtask

    task automatic test_free_in_send();
        i_drive = 1'b1; i_sel = 1'b0; i_data = 2'b10;
        step();
        idle_inputs();
        n_checks++; if (o_drive0 !== 1'b1) begin n_fail++; $display("FAIL send_drv0 got=%b want=1", o_drive0); end
        i_free0 = 1'b1;
        step();
        idle_inputs();
        n_checks++; if (o_drive0 !== 1'b0) begin n_fail++; $display("FAIL send_freed drv0 got=%b want=0", o_drive0); end
        i_drive = 1'b1; i_sel = 1'b0; i_data = 2'b11;
        step();
        idle_inputs();
        n_checks++; if ({o_drive0, o_data0, o_free} !== 4'b1_11_1) begin n_fail++; $display("FAIL send_next {drv0,dat0,free} got=%b want=1111", {o_drive0, o_data0, o_free}); end
        step();
    endtask

    task automatic test_back_to_back();
        // Slot 0 currently WAIT with 2'b11; free and new token at same edge
        i_drive = 1'b1; i_sel = 1'b0; i_data = 2'b01; i_free0 = 1'b1;
        step();
        idle_inputs();
        n_checks++; if ({o_drive0, o_data0, o_free} !== 4'b1_01_1) begin n_fail++; $display("FAIL b2b_reuse {drv0,dat0,free} got=%b want=1011", {o_drive0, o_data0, o_free}); end
        step();
        i_drive = 1'b1; i_sel = 1'b1; i_data = 2'b10;
        step();
        idle_inputs();
        n_checks++; if ({o_drive1, o_data1, o_drive0} !== 4'b1_10_0) begin n_fail++; $display("FAIL b2b_slot1 {drv1,dat1,drv0} got=%b want=1100", {o_drive1, o_data1, o_drive0}); end
        // Both frees in the same cycle (slot 0 WAIT, slot 1 SEND)
        i_free0 = 1'b1; i_free1 = 1'b1;
        step();
        idle_inputs();
        i_drive = 1'b1; i_sel = 1'b1; i_data = 2'b11;
        step();
        n_checks++; if ({o_drive1, o_data1, o_free} !== 4'b1_11_1) begin n_fail++; $display("FAIL dual_free1 {drv1,dat1,free} got=%b want=1111", {o_drive1, o_data1, o_free}); end
        i_sel = 1'b0; i_data = 2'b10;
        step();
        idle_inputs();
        n_checks++; if ({o_drive0, o_data0, o_free} !== 4'b1_10_1) begin n_fail++; $display("FAIL dual_free0 {drv0,dat0,free} got=%b want=1101", {o_drive0, o_data0, o_free}); end
        i_free0 = 1'b1; i_free1 = 1'b1;
        step();
        idle_inputs();
    endtask

    task automatic test_proto_err();
        i_drive = 1'b1; i_sel = 1'b1; i_data = 2'b01;
        step();
        i_data = 2'b10;
        step();
        n_checks++; if ({o_free, o_proto_err} !== 2'b00) begin n_fail++; $display("FAIL perr_pend {free,err} got=%b want=00", {o_free, o_proto_err}); end
        i_data = 2'b11;
        step();
        idle_inputs();
        n_checks++; if ({o_proto_err, o_drive1, o_free} !== 3'b100) begin n_fail++; $display("FAIL perr_set {err,drv1,free} got=%b want=100", {o_proto_err, o_drive1, o_free}); end
        i_free1 = 1'b1;
        step();
        idle_inputs();
        n_checks++; if ({o_drive1, o_data1, o_free} !== 4'b1_10_1) begin n_fail++; $display("FAIL perr_drain {drv1,dat1,free} got=%b want=1101", {o_drive1, o_data1, o_free}); end
        i_free1 = 1'b1;
        step();
        idle_inputs();
        for (int k = 0; k < 4; k++) begin
            step();
            n_checks++; if ({o_drive0, o_drive1, o_free, o_proto_err} !== 4'b0001) begin n_fail++; $display("FAIL perr_quiet cycle %0d {drv0,drv1,free,err} got=%b want=0001", k, {o_drive0, o_drive1, o_free, o_proto_err}); end
        end
    endtask

    task automatic test_reset_midflight();
        i_drive = 1'b1; i_sel = 1'b1; i_data = 2'b01;
        step();
        i_data = 2'b10;
        step();
        idle_inputs();
        rst = 1'b1;
        for (int k = 0; k < 2; k++) begin
            step();
            n_checks++; if ({o_free, o_drive0, o_drive1, o_data0, o_data1, o_proto_err} !== 8'h00) begin n_fail++; $display("FAIL rstmid_outs cycle %0d got=%b want=00000000", k, {o_free, o_drive0, o_drive1, o_data0, o_data1, o_proto_err}); end
        end
        rst = 1'b0;
        step();
        n_checks++; if ({o_free, o_drive0, o_drive1} !== 3'b100) begin n_fail++; $display("FAIL rstmid_credit {free,drv0,drv1} got=%b want=100", {o_free, o_drive0, o_drive1}); end
        step();
        n_checks++; if ({o_free, o_drive0, o_drive1} !== 3'b000) begin n_fail++; $display("FAIL rstmid_quiet {free,drv0,drv1} got=%b want=000", {o_free, o_drive0, o_drive1}); end
        i_drive = 1'b1; i_sel = 1'b1; i_data = 2'b11;
        step();
        idle_inputs();
        n_checks++; if ({o_drive1, o_data1, o_free} !== 4'b1_11_1) begin n_fail++; $display("FAIL rstmid_route {drv1,dat1,free} got=%b want=1111", {o_drive1, o_data1, o_free}); end
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        rst      = 1'b1;
        idle_inputs();
        test_reset();
        test_single_route();
        test_pending_stall();
        test_free_in_send();
        test_back_to_back();
        test_proto_err();
        test_reset_midflight();
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/c_demux2_2b_cache.md
# c_demux2_2b_cache

Synchronous two-way demultiplexer for the cache control handshake network. It is the split-side counterpart of the two-input mutex merge. A single drive/free token channel comes in, and each token is steered by `i_sel` to one of two downstream drive/free channels. Each output has a one-entry holding slot, and one pending register absorbs a token whose target slot is still busy. Upstream gets a one-cycle `o_free` pulse each time a token is handed into an output slot.

## Interface
- `DATA_W`, default 2: token payload width.
- `clk` input 1: clock, rising edge.
- `rst` input 1: synchronous, active-high reset.
- `i_drive` input 1: one-cycle pulse, upstream token valid.
- `i_data` input DATA_W: token payload, valid while `i_drive`=1.
- `i_sel` input 1: destination select, 0 → output 0, 1 → output 1, valid while `i_drive`=1.
- `o_free` output 1: one-cycle pulse, upstream may issue its next token.
- `o_drive0` / `o_drive1` output 1: one-cycle pulse, token presented on output 0 / 1.
- `o_data0` / `o_data1` output DATA_W: slot payload, held from the drive pulse until the free is accepted.
- `i_free0` / `i_free1` input 1: one-cycle pulse, downstream 0 / 1 has consumed the token.
- `o_proto_err` output 1: sticky flag, upstream protocol violation.

## Operation
- Per-output state machine, states EMPTY, SEND and WAIT:
  - EMPTY→SEND when a token loads into the slot. The slot payload is registered in the same step.
  - SEND lasts exactly one cycle, with `o_driveN`=1. It moves to WAIT, or directly to EMPTY if `i_freeN`=1 in that cycle.
  - WAIT→EMPTY when `i_freeN`=1.
  - `i_freeN` in EMPTY is ignored.
- Pending register: holds valid, sel and data.
- Token acceptance at each edge where `i_drive`=1:
  - If the target slot is EMPTY, or is being freed at this same edge, the token loads into the slot and `o_free` pulses next cycle.
  - Otherwise the token goes into pending and no `o_free` is issued.
- Pending drain: at any edge where the pending target slot is EMPTY or being freed, pending moves into the slot, pending is cleared, and `o_free` pulses next cycle.
- Protocol violation: `i_drive`=1 while pending is valid.
  - The new token is dropped and `o_proto_err` is set.
  - Pending and slot contents are unchanged.
- Upstream rule: exactly one `o_free` per accepted token, plus one initial credit.
  - A compliant upstream therefore never has more than one token outstanding.
  - The pending register and the incoming `i_drive` are never both sources of a load at the same edge.
- `o_dataN` holds the slot value through SEND and WAIT, and keeps its last value while EMPTY.

## Timing
- Reset: while `rst`=1 at an edge, all registered state clears at that edge.
  - Slots go to EMPTY, pending is cleared, `o_drive0`/`o_drive1`=0, `o_data0`/`o_data1`=0, `o_free`=0, `o_proto_err`=0.
- Initial credit: `o_free`=1 in the first cycle after the first edge with `rst`=0, for one cycle only.
- Latency when the target slot is EMPTY: `i_drive` sampled at edge t gives `o_driveN`=1 and `o_free`=1 in the cycle after t, so the forward latency is 1 cycle.
- Freed-slot reuse: `i_freeN` sampled at edge u loads a waiting token (pending or a new `i_drive`) at u. `o_driveN` pulses in the cycle after u, giving back-to-back reuse with no bubble.
- A free arriving in the SEND cycle completes the token. The slot returns to EMPTY at that edge, or reloads if a token is waiting.
- Both outputs run independently. `i_free0` and `i_free1` arriving in the same cycle are both honoured.
- Reset mid-operation: in-flight and pending tokens are discarded without any `o_free`. The initial credit is reissued after reset.
- All outputs are registered; there are no combinational paths from input to output.

## Test plan
- Reset and initial credit: hold `rst` for 3 cycles, then release → all outputs 0 during reset, then `o_free`=1 for exactly one cycle, then 0.
- Single routing:
  - `i_drive`=1, `i_sel`=1, `i_data`=2'b10 → next cycle `o_drive1`=1, `o_data1`=2'b10, `o_free`=1, `o_drive0`=0.
  - `i_free1` pulse → slot 1 returns to EMPTY.
- Pending stall:
  - Send to output 0 twice without `i_free0` → second token held in pending, no second `o_free`.
  - `i_free0` at edge u → `o_drive0` with the second payload and `o_free`, both in the cycle after u.
- Free during SEND: `i_free0`=1 in the same cycle as `o_drive0` → slot 0 EMPTY next cycle, and a following token routes with 1-cycle latency.
- Protocol error: issue `i_drive` while pending is valid → `o_proto_err`=1 and stays set, the dropped payload never appears on any output, and the pending payload still delivers.
- Reset mid-flight: assert `rst` while slot 1 is in WAIT and pending is valid → no `o_drive` or `o_free` from the old tokens, and the initial `o_free` is reissued after release.
